peridot_board_romreader: RTL and testbench



---
 rtl/peridot_board_romreader_if.sv | 25 ++
 rtl/peridot_board_romreader.sv | 165 ++++++++++++++++
 tb/tb_peridot_board_romreader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/peridot_board_romreader_if.sv
// rtl/peridot_board_romreader_if.sv - ROM byte bus plus request/result signals of the PERIDOT board ROM reader.
// The reader is the master of the ROM byte bus; the host/ROM side uses the slave view.
interface peridot_board_romreader_if;
    logic        start;
    logic        rom_ready;
    logic [4:0]  byteaddr;
    logic [7:0]  bytedata;
    logic        busy;
    logic        done;
    logic        valid;
    logic [2:0]  errcode;
    logic [7:0]  version;
    logic [7:0]  gencode;
    logic [63:0] uid;

    modport master (
        input  start, rom_ready, bytedata,
        output byteaddr, busy, done, valid, errcode, version, gencode, uid
    );

    modport slave (
        output start, rom_ready, bytedata,
        input  byteaddr, busy, done, valid, errcode, version, gencode, uid
    );
endinterface

// File: rtl/peridot_board_romreader.sv
// rtl/peridot_board_romreader.sv - Fetches and checks the 26-byte PERIDOT board record and parses its 64-bit UID.
// Optional macro PERIDOT_ROMREADER_LOWERCASE_EN: UID characters may also be lowercase 'a'..'f'.
module peridot_board_romreader #(
    parameter logic [7:0]  EXPECT_GENCODE = 8'h4e,
    parameter              GENCODE_CHECK  = "ENABLE",
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned READY_TIMEOUT  = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    peridot_board_romreader_if.master  rom
);
    localparam bit          GEN_EN = (GENCODE_CHECK == "ENABLE");
    localparam logic [2:0]  LAT    = READ_LATENCY[2:0];
    localparam logic [15:0] TMO    = READY_TIMEOUT[15:0];

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_TIMEOUT = 3'd1;
    localparam logic [2:0] ERR_MAGIC   = 3'd2;
    localparam logic [2:0] ERR_VERSION = 3'd3;
    localparam logic [2:0] ERR_GENCODE = 3'd4;
    localparam logic [2:0] ERR_HEX     = 3'd5;
    localparam logic [2:0] ERR_RDYLOST = 3'd6;

    typedef enum logic [1:0] {IDLE, WAITRDY, FETCH, DONE} state_t;

    state_t      state_q;
    logic [4:0]  byteaddr_q;
    logic [2:0]  hold_q;
    logic [15:0] tmo_q;
    logic [63:0] uid_sh_q;
    logic [7:0]  ver_sh_q;
    logic [7:0]  gen_sh_q;
    logic        busy_q;
    logic        done_q;
    logic        valid_q;
    logic [2:0]  errcode_q;
    logic [7:0]  version_q;
    logic [7:0]  gencode_q;
    logic [63:0] uid_q;

    logic [2:0]  chk_err_d;
    logic [3:0]  nib_d;
    logic [7:0]  b;

    assign b = rom.bytedata;

    // Verdict on the byte currently presented for byteaddr_q.
    always_comb begin
        chk_err_d = ERR_OK;
        nib_d     = 4'd0;
        case (byteaddr_q)
            5'd0, 5'd4: if (b != 8'h4a) chk_err_d = ERR_MAGIC;
            5'd1, 5'd5: if (b != 8'h37) chk_err_d = ERR_MAGIC;
            5'd2:       if (b != 8'h57) chk_err_d = ERR_MAGIC;
            5'd6:       if (b != 8'h32) chk_err_d = ERR_MAGIC;
            5'd8:       if (b != 8'h39) chk_err_d = ERR_MAGIC;
            5'd9:       if (b != 8'h33) chk_err_d = ERR_MAGIC;
            5'd3:       if (b != 8'h02) chk_err_d = ERR_VERSION;
            5'd7:       if (GEN_EN && (b != EXPECT_GENCODE)) chk_err_d = ERR_GENCODE;
            default: begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    nib_d = b[3:0];
                end else if (b >= 8'h41 && b <= 8'h46) begin
                    nib_d = b[3:0] + 4'd9;
`ifdef PERIDOT_ROMREADER_LOWERCASE_EN
                end else if (b >= 8'h61 && b <= 8'h66) begin
                    nib_d = b[3:0] + 4'd9;
`endif
                end else begin
                    chk_err_d = ERR_HEX;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byteaddr_q <= 5'd0;
            hold_q     <= 3'd0;
            tmo_q      <= 16'd0;
            uid_sh_q   <= 64'd0;
            ver_sh_q   <= 8'd0;
            gen_sh_q   <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            errcode_q  <= ERR_OK;
            version_q  <= 8'd0;
            gencode_q  <= 8'd0;
            uid_q      <= 64'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    byteaddr_q <= 5'd0;
                    if (rom.start) begin
                        state_q  <= WAITRDY;
                        busy_q   <= 1'b1;
                        tmo_q    <= 16'd0;
                        hold_q   <= 3'd0;
                        uid_sh_q <= 64'd0;
                    end
                end
                WAITRDY: begin
                    if (rom.rom_ready) begin
                        state_q <= FETCH;
                        hold_q  <= 3'd0;
                    end else if (tmo_q == TMO - 16'd1) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        errcode_q <= ERR_TIMEOUT;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                FETCH: begin
                    if (!rom.rom_ready || (hold_q == LAT && chk_err_d != ERR_OK)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        errcode_q <= rom.rom_ready ? chk_err_d : ERR_RDYLOST;
                    end else if (hold_q != LAT) begin
                        hold_q <= hold_q + 3'd1;
                    end else begin
                        if (byteaddr_q == 5'd3) ver_sh_q <= b;
                        if (byteaddr_q == 5'd7) gen_sh_q <= b;
                        if (byteaddr_q >= 5'd10) uid_sh_q <= {uid_sh_q[59:0], nib_d};
                        if (byteaddr_q == 5'd25) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            valid_q   <= 1'b1;
                            errcode_q <= ERR_OK;
                            uid_q     <= {uid_sh_q[59:0], nib_d};
                            version_q <= ver_sh_q;
                            gencode_q <= gen_sh_q;
                        end else begin
                            byteaddr_q <= byteaddr_q + 5'd1;
                            hold_q     <= 3'd0;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    byteaddr_q <= 5'd0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom.byteaddr = byteaddr_q;
    assign rom.busy     = busy_q;
    assign rom.done     = done_q;
    assign rom.valid    = valid_q;
    assign rom.errcode  = errcode_q;
    assign rom.version  = version_q;
    assign rom.gencode  = gencode_q;
    assign rom.uid      = uid_q;
endmodule

// File: tb/tb_peridot_board_romreader.sv
// tb/tb_peridot_board_romreader.sv - Self-checking bench for peridot_board_romreader against a record-level model.
module tb_peridot_board_romreader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rdy;
    logic       st [3];
    logic [7:0] rom [0:31];
    logic [7:0] p1, p2;

    peridot_board_romreader_if if0 ();
    peridot_board_romreader_if if1 ();
    peridot_board_romreader_if if2 ();

    peridot_board_romreader #(.READ_LATENCY(0), .READY_TIMEOUT(10))
        u0 (.clk(clk), .reset(reset), .rom(if0));
    peridot_board_romreader #(.READ_LATENCY(2), .READY_TIMEOUT(10))
        u1 (.clk(clk), .reset(reset), .rom(if1));
    peridot_board_romreader #(.GENCODE_CHECK("DISABLE"), .READ_LATENCY(0), .READY_TIMEOUT(10))
        u2 (.clk(clk), .reset(reset), .rom(if2));

    assign if0.start = st[0];
    assign if1.start = st[1];
    assign if2.start = st[2];
    assign if0.rom_ready = rdy;
    assign if1.rom_ready = rdy;
    assign if2.rom_ready = rdy;
    assign if0.bytedata = rom[if0.byteaddr];
    assign if2.bytedata = rom[if2.byteaddr];

    // Two-cycle ROM for the READ_LATENCY=2 instance.
    always @(posedge clk) begin
        p1 <= rom[if1.byteaddr];
        p2 <= p1;
    end
    assign if1.bytedata = p2;

    logic [4:0]  a_w [3];
    logic        b_w [3], d_w [3], v_w [3];
    logic [2:0]  e_w [3];
    logic [7:0]  ver_w [3], gen_w [3];
    logic [63:0] uid_w [3];
    assign a_w[0] = if0.byteaddr; assign a_w[1] = if1.byteaddr; assign a_w[2] = if2.byteaddr;
    assign b_w[0] = if0.busy;     assign b_w[1] = if1.busy;     assign b_w[2] = if2.busy;
    assign d_w[0] = if0.done;     assign d_w[1] = if1.done;     assign d_w[2] = if2.done;
    assign v_w[0] = if0.valid;    assign v_w[1] = if1.valid;    assign v_w[2] = if2.valid;
    assign e_w[0] = if0.errcode;  assign e_w[1] = if1.errcode;  assign e_w[2] = if2.errcode;
    assign ver_w[0] = if0.version; assign ver_w[1] = if1.version; assign ver_w[2] = if2.version;
    assign gen_w[0] = if0.gencode; assign gen_w[1] = if1.gencode; assign gen_w[2] = if2.gencode;
    assign uid_w[0] = if0.uid;    assign uid_w[1] = if1.uid;    assign uid_w[2] = if2.uid;

    bit          gen_en [3] = '{1'b1, 1'b1, 1'b0};
    int          lat    [3] = '{0, 2, 0};
    logic [63:0] e_uid  [3];
    logic [7:0]  e_ver  [3], e_gen [3];
    logic        e_valid[3];
    int          hist   [32];
    int          max_addr;
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] magic(input int n);
        case (n)
            0, 4:    return 8'h4a;
            1, 5:    return 8'h37;
            2:       return 8'h57;
            6:       return 8'h32;
            8:       return 8'h39;
            9:       return 8'h33;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef PERIDOT_ROMREADER_LOWERCASE_EN
        if (c >= "a" && c <= "f") return int'(c) - 87;
`endif
        return -1;
    endfunction

    // Record-level reference: first failing byte decides the result.
    function automatic void model(input bit gchk, output logic [2:0] err, output int last,
                                  output logic [63:0] u);
        int v;
        err = 3'd0; last = 25; u = 64'd0;
        for (int n = 0; n < 26; n++) begin
            if (n == 3) begin
                if (rom[n] != 8'h02) err = 3'd3;
            end else if (n == 7) begin
                if (gchk && rom[n] != 8'h4e) err = 3'd4;
            end else if (n < 10) begin
                if (rom[n] != magic(n)) err = 3'd2;
            end else begin
                v = hexval(rom[n]);
                if (v < 0) err = 3'd5;
                else u = (u << 4) | 64'(v);
            end
            if (err != 3'd0) begin
                last = n;
                return;
            end
        end
    endfunction

    task automatic build_rom(input logic [63:0] uid, input logic [7:0] gen);
        logic [3:0] v;
        for (int n = 0; n < 10; n++) rom[n] = magic(n);
        rom[3] = 8'h02;
        rom[7] = gen;
        for (int i = 0; i < 16; i++) begin
            v = uid[63 - 4*i -: 4];
            if (v < 4'd10) rom[10+i] = 8'h30 + 8'(v);
            else rom[10+i] = 8'h37 + 8'(v);
`ifdef PERIDOT_ROMREADER_LOWERCASE_EN
            if (v >= 4'd10 && $urandom_range(0, 1) == 1) rom[10+i] = 8'h57 + 8'(v);
`endif
        end
    endtask

    task automatic do_read(input int k, input int drop_at, input bit poke, input int budget,
                           output int cyc, output int la);
        for (int i = 0; i < 32; i++) hist[i] = 0;
        max_addr = 0;
        @(negedge clk); st[k] = 1'b1;
        @(posedge clk); #1; st[k] = 1'b0;
        cyc = 1;
        while (d_w[k] !== 1'b1 && cyc < budget) begin
            if (cyc >= 2) hist[a_w[k]]++;
            if (int'(a_w[k]) > max_addr) max_addr = int'(a_w[k]);
            if (int'(a_w[k]) == drop_at) rdy = 1'b0;
            if (poke && cyc == 10) st[k] = 1'b1;
            if (poke && cyc == 11) st[k] = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        st[k] = 1'b0;
        if (d_w[k] !== 1'b1) chk("done_within_budget", {63'd0, d_w[k]}, 64'd1);
        la = int'(a_w[k]);
    endtask

    task automatic run_and_check(input int k, input int drop_at, input bit poke);
        logic [2:0]  err;
        logic [63:0] u;
        int last, cyc, la, bad, dones;
        model(gen_en[k], err, last, u);
        if (drop_at >= 0) begin err = 3'd6; last = drop_at; end
        do_read(k, drop_at, poke, 400, cyc, la);
        chk($sformatf("cycles k%0d", k), 64'(cyc), 64'(2 + (last + 1) * (lat[k] + 1)));
        chk($sformatf("errcode k%0d", k), 64'(e_w[k]), 64'(err));
        chk($sformatf("last_addr k%0d", k), 64'(la), 64'(last));
        chk($sformatf("busy_at_done k%0d", k), 64'(b_w[k]), 64'd0);
        if (err == 3'd0) begin
            e_uid[k] = u; e_ver[k] = rom[3]; e_gen[k] = rom[7]; e_valid[k] = 1'b1;
            bad = 0;
            for (int n = 0; n < 26; n++) if (hist[n] != lat[k] + 1) bad++;
            chk($sformatf("addr_sweep k%0d", k), 64'(bad), 64'd0);
        end else begin
            e_valid[k] = 1'b0;
        end
        chk($sformatf("valid k%0d", k), 64'(v_w[k]), 64'(e_valid[k]));
        chk($sformatf("uid k%0d", k), uid_w[k], e_uid[k]);
        chk($sformatf("version k%0d", k), 64'(ver_w[k]), 64'(e_ver[k]));
        chk($sformatf("gencode k%0d", k), 64'(gen_w[k]), 64'(e_gen[k]));
        dones = 0;
        repeat (poke ? 6 : 1) begin
            @(posedge clk); #1;
            if (d_w[k] === 1'b1) dones++;
        end
        chk($sformatf("extra_done k%0d", k), 64'(dones), 64'd0);
        chk($sformatf("idle_addr k%0d", k), 64'(a_w[k]), 64'd0);
        chk($sformatf("idle_busy k%0d", k), 64'(b_w[k]), 64'd0);
        rdy = 1'b1;
    endtask

    task automatic check_reset_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s flags k%0d", tag, k),
                64'({a_w[k], b_w[k], d_w[k], v_w[k], e_w[k], ver_w[k], gen_w[k]}), 64'd0);
            chk($sformatf("%s uid k%0d", tag, k), uid_w[k], 64'd0);
            e_uid[k] = 64'd0; e_ver[k] = 8'd0; e_gen[k] = 8'd0; e_valid[k] = 1'b0;
        end
    endtask

    initial begin
        int cyc, la, n;
        reset = 1'b1; rdy = 1'b1;
        st[0] = 1'b0; st[1] = 1'b0; st[2] = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_all("reset");
        @(negedge clk); reset = 1'b0;

        build_rom(64'h0123456789abcdef, 8'h4e);
        run_and_check(0, -1, 1'b0);
        chk("fixed_uid", uid_w[0], 64'h0123456789abcdef);
        run_and_check(1, -1, 1'b0);
        run_and_check(2, -1, 1'b0);

        for (int it = 0; it < 10; it++) begin
            build_rom({$urandom(), $urandom()}, 8'h4e);
            if ($urandom_range(0, 1) == 1) rom[$urandom_range(0, 25)] = 8'($urandom_range(0, 255));
            run_and_check($urandom_range(0, 2), -1, 1'b0);
        end

        rdy = 1'b0;
        do_read(0, -1, 1'b0, 100, cyc, la);
        chk("tmo_cycles", 64'(cyc), 64'd11);
        chk("tmo_errcode", 64'(e_w[0]), 64'd1);
        chk("tmo_valid", 64'(v_w[0]), 64'd0);
        chk("tmo_max_addr", 64'(max_addr), 64'd0);
        chk("tmo_uid_kept", uid_w[0], e_uid[0]);
        e_valid[0] = 1'b0;
        @(posedge clk); #1;
        rdy = 1'b1;

        build_rom({$urandom(), $urandom()}, 8'h4e);
        rom[3] = 8'h03;
        run_and_check(0, -1, 1'b0);
        chk("ver_err", 64'(e_w[0]), 64'd3);

        build_rom({$urandom(), $urandom()}, 8'h41);
        run_and_check(0, -1, 1'b0);
        chk("gen_err", 64'(e_w[0]), 64'd4);
        run_and_check(2, -1, 1'b0);
        chk("gen_nocheck", 64'(gen_w[2]), 64'h41);

        build_rom(64'h0123456789abcdef, 8'h4e);
        run_and_check(0, -1, 1'b0);
        rom[15] = 8'h61;
        run_and_check(0, -1, 1'b0);
`ifdef PERIDOT_ROMREADER_LOWERCASE_EN
        chk("lower_ok", 64'(e_w[0]), 64'd0);
        chk("lower_nibble5", 64'(uid_w[0][43:40]), 64'ha);
`else
        chk("lower_rej", 64'(e_w[0]), 64'd5);
        chk("lower_uid_kept", uid_w[0], 64'h0123456789abcdef);
`endif

        build_rom({$urandom(), $urandom()}, 8'h4e);
        run_and_check(0, 12, 1'b0);
        run_and_check(0, -1, 1'b1);

        @(negedge clk); st[0] = 1'b1;
        @(posedge clk); #1; st[0] = 1'b0;
        n = 0;
        while (a_w[0] !== 5'd20 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_addr20", 64'(a_w[0]), 64'd20);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_all("midreset");
        @(negedge clk); reset = 1'b0;

        build_rom({$urandom(), $urandom()}, 8'h4e);
        run_and_check(1, -1, 1'b0);
        run_and_check(0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
